// File: rtl/trace_lockstep_pkg.sv
// Shared constants and the masked lane-compare helper for the lockstep comparator.
package trace_lockstep_pkg;

    localparam logic LEAD_A = 1'b0;
    localparam logic LEAD_B = 1'b1;

    // Upper bounds for the compare helper; callers zero-extend into these widths.
    localparam int unsigned MAX_DATA_W = 256;
    localparam int unsigned MAX_LANES  = 32;
    localparam int unsigned DATA_IDX_W = $clog2(MAX_DATA_W);
    localparam int unsigned LANE_IDX_W = $clog2(MAX_LANES);

    // Masks must agree; data must agree in every lane enabled by the expected mask.
    function automatic logic lanes_equal(
        input logic [MAX_DATA_W-1:0] exp_d,
        input logic [MAX_DATA_W-1:0] act_d,
        input logic [MAX_LANES-1:0]  exp_m,
        input logic [MAX_LANES-1:0]  act_m,
        input int unsigned           data_w,
        input int unsigned           mask_w
    );
        logic        eq;
        int unsigned lane_w;
        eq     = (exp_m == act_m);
        lane_w = data_w / mask_w;
        for (int unsigned j = 0; j < MAX_DATA_W; j++) begin
            if (j < data_w) begin
                if (exp_m[LANE_IDX_W'(j / lane_w)] &&
                    (exp_d[DATA_IDX_W'(j)] != act_d[DATA_IDX_W'(j)])) begin
                    eq = 1'b0;
                end
            end
        end
        return eq;
    endfunction

endpackage

// File: rtl/trace_lockstep_fifo.sv
// Circular skew buffer with wrap-around pointers; push and pop may coincide, even when full.
module trace_lockstep_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 37
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   i_clr,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [W-1:0]           i_data,
    output logic [W-1:0]           o_head_c,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (i_push && !i_clr) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_c = r_mem[r_rd_ptr];
    assign o_count  = r_count;

endmodule

// File: rtl/trace_lockstep_cmp.sv
// Lockstep comparator for two item streams with bounded skew, masked lane compare and sticky errors.
module trace_lockstep_cmp
    import trace_lockstep_pkg::*;
#(
    parameter int unsigned DATA_W = 36,
    parameter int unsigned MASK_W = 1,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   clr,
    input  logic                   a_valid,
    input  logic [DATA_W-1:0]      a_data,
    input  logic [MASK_W-1:0]      a_mask,
    input  logic                   b_valid,
    input  logic [DATA_W-1:0]      b_data,
    input  logic [MASK_W-1:0]      b_mask,
    output logic                   match,
    output logic                   mismatch,
    output logic                   err_mismatch,
    output logic                   err_overflow,
    output logic [DATA_W-1:0]      first_exp,
    output logic [DATA_W-1:0]      first_act,
    output logic [$clog2(DEPTH):0] skew,
    output logic                   lead_b,
    output logic [CNT_W-1:0]       cmp_count
);

    localparam int unsigned ITEM_W = MASK_W + DATA_W;
    localparam int unsigned SKEW_W = $clog2(DEPTH) + 1;

    logic [ITEM_W-1:0] w_a_item;
    logic [ITEM_W-1:0] w_b_item;
    logic [ITEM_W-1:0] w_one_item;
    logic              w_one_side;
    logic [ITEM_W-1:0] w_head;
    logic [SKEW_W-1:0] w_count;
    logic              w_cnt_zero;
    logic              w_full;

    logic              w_push;
    logic              w_pop;
    logic [ITEM_W-1:0] w_push_item;
    logic              w_cmp;
    logic              w_ovf;
    logic              w_set_lead;
    logic [ITEM_W-1:0] w_exp;
    logic [ITEM_W-1:0] w_act;
    logic              w_eq;

    logic              r_lead;
    logic              r_match;
    logic              r_mismatch;
    logic              r_err_mm;
    logic              r_err_ovf;
    logic [DATA_W-1:0] r_first_exp;
    logic [DATA_W-1:0] r_first_act;
    logic [CNT_W-1:0]  r_cnt;

    assign w_a_item   = {a_mask, a_data};
    assign w_b_item   = {b_mask, b_data};
    assign w_one_side = b_valid ? LEAD_B : LEAD_A;
    assign w_one_item = b_valid ? w_b_item : w_a_item;
    assign w_cnt_zero = (w_count == '0);
    assign w_full     = (w_count == SKEW_W'(DEPTH));

    trace_lockstep_fifo #(
        .DEPTH (DEPTH),
        .W     (ITEM_W)
    ) u_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .i_clr    (clr),
        .i_push   (w_push),
        .i_pop    (w_pop),
        .i_data   (w_push_item),
        .o_head_c (w_head),
        .o_count  (w_count)
    );

    // Action decode: the expected side is always the FIFO head when skewed, else A.
    always_comb begin
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_push_item = '0;
        w_cmp       = 1'b0;
        w_ovf       = 1'b0;
        w_set_lead  = 1'b0;
        w_exp       = '0;
        w_act       = '0;
        if (!clr) begin
            if (a_valid && b_valid) begin
                w_cmp = 1'b1;
                if (w_cnt_zero) begin
                    w_exp = w_a_item;
                    w_act = w_b_item;
                end else begin
                    w_exp       = w_head;
                    w_act       = (r_lead == LEAD_B) ? w_a_item : w_b_item;
                    w_pop       = 1'b1;
                    w_push      = 1'b1;
                    w_push_item = (r_lead == LEAD_B) ? w_b_item : w_a_item;
                end
            end else if (a_valid || b_valid) begin
                if (w_cnt_zero) begin
                    w_push      = 1'b1;
                    w_push_item = w_one_item;
                    w_set_lead  = 1'b1;
                end else if (w_one_side == r_lead) begin
                    if (!w_full) begin
                        w_push      = 1'b1;
                        w_push_item = w_one_item;
                    end else begin
                        w_ovf = 1'b1;
                    end
                end else begin
                    w_cmp = 1'b1;
                    w_pop = 1'b1;
                    w_exp = w_head;
                    w_act = w_one_item;
                end
            end
        end
    end

    assign w_eq = lanes_equal(MAX_DATA_W'(w_exp[DATA_W-1:0]), MAX_DATA_W'(w_act[DATA_W-1:0]),
                              MAX_LANES'(w_exp[ITEM_W-1:DATA_W]), MAX_LANES'(w_act[ITEM_W-1:DATA_W]),
                              DATA_W, MASK_W);

    // Result pulses, sticky errors, first-mismatch capture and saturating counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_lead      <= LEAD_A;
            r_match     <= 1'b0;
            r_mismatch  <= 1'b0;
            r_err_mm    <= 1'b0;
            r_err_ovf   <= 1'b0;
            r_first_exp <= '0;
            r_first_act <= '0;
            r_cnt       <= '0;
        end else if (clr) begin
            r_lead      <= LEAD_A;
            r_match     <= 1'b0;
            r_mismatch  <= 1'b0;
            r_err_mm    <= 1'b0;
            r_err_ovf   <= 1'b0;
            r_first_exp <= '0;
            r_first_act <= '0;
            r_cnt       <= '0;
        end else begin
            r_match    <= w_cmp & w_eq;
            r_mismatch <= w_cmp & ~w_eq;
            if (w_set_lead) r_lead <= w_one_side;
            if (w_ovf) r_err_ovf <= 1'b1;
            if (w_cmp && !w_eq && !r_err_mm) begin
                r_err_mm    <= 1'b1;
                r_first_exp <= w_exp[DATA_W-1:0];
                r_first_act <= w_act[DATA_W-1:0];
            end
            if (w_cmp && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign match        = r_match;
    assign mismatch     = r_mismatch;
    assign err_mismatch = r_err_mm;
    assign err_overflow = r_err_ovf;
    assign first_exp    = r_first_exp;
    assign first_act    = r_first_act;
    assign skew         = w_count;
    assign lead_b       = r_lead;
    assign cmp_count    = r_cnt;

endmodule
